clk_tick_gen: RTL and testbench

Parametrised multi-channel clock-enable generator that derives single-cycle tick strobes, and optionally square-wave outputs, from the system clock. Each channel has its own runtime-programmable divisor, with glitch-free reload at the channel's wrap point. It replaces fixed power-of-two counter taps. Downstream logic (VGA timing, debounce, display scan, game-step logic) stays on `clk` and qualifies its registers with `tick[n]`, rather than clocking from divided nets.

---
 rtl/clk_tick_gen.sv | 117 +++++++++++
 tb/tb_clk_tick_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_tick_gen.sv
// Multi-channel clock-enable generator: per-channel runtime divisor, one-cycle tick strobes, optional square waves.
// Latency: outputs registered; first tick lands DIV_RST counting edges after reset release; cfg_pending one cycle after cfg_we.
// Backpressure: none; free-running strobes; divisor writes are held pending and applied at the channel wrap (or when idle/sync).
// Optional feature: define CLK_TICK_GEN_SQ_EN to build the sq square-wave flops; otherwise sq is constant 0.
module clk_tick_gen #(
    parameter int  CH      = 3,
    parameter int  W       = 21,
    parameter int  DIV_RST = 4,
    localparam int CHW     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           sync,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [W-1:0]   cfg_div,
    output logic [CH-1:0]  tick,
    output logic [CH-1:0]  sq,
    output logic [CH-1:0]  cfg_pending
);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [W-1:0] cnt_q, cnt_d;
        logic [W-1:0] div_q, div_d;
        logic [W-1:0] pdiv_q, pdiv_d;
        logic         pend_q, pend_d;
        logic         tick_q, tick_d;
        logic         run, wrap, apply, wr;

        // A channel counts only when globally enabled, not realigning, and not disabled by div==0.
        // div==0 is excluded before the div-1 compare, so the subtraction never underflows.
        assign run   = en & ~sync & (div_q != '0);
        assign wrap  = run & (cnt_q == div_q - W'(1));
        // Pending divisor lands only where it cannot distort a period in progress.
        assign apply = pend_q & (sync | ~en | (div_q == '0) | wrap);
        // Out-of-range channel indices match no channel and are dropped.
        assign wr    = cfg_we & (cfg_ch == CHW'(g));

        // Counter and tick strobe next-state; sync has priority over counting.
        always_comb begin
            cnt_d  = cnt_q;
            tick_d = 1'b0;
            if (sync) begin
                cnt_d = '0;
            end else if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else if (run) begin
                cnt_d = cnt_q + W'(1);
            end
        end

        // Divisor staging: apply first, then a same-edge write re-arms pending with the newest value.
        always_comb begin
            div_d  = div_q;
            pdiv_d = pdiv_q;
            pend_d = pend_q;
            if (apply) begin
                div_d  = pdiv_q;
                pend_d = 1'b0;
            end
            if (wr) begin
                pdiv_d = cfg_div;
                pend_d = 1'b1;
            end
        end

        // Channel state registers; reset aborts any partial period.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                div_q  <= W'(DIV_RST);
                pdiv_q <= '0;
                pend_q <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                pdiv_q <= pdiv_d;
                pend_q <= pend_d;
                tick_q <= tick_d;
            end
        end

`ifdef CLK_TICK_GEN_SQ_EN
        logic sq_q, sq_d;

        // Square wave toggles on every wrap, so its period is twice the tick period.
        always_comb begin
            sq_d = sq_q;
            if (sync) begin
                sq_d = 1'b0;
            end else if (wrap) begin
                sq_d = ~sq_q;
            end
        end

        // Square-wave register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sq_q <= 1'b0;
            end else begin
                sq_q <= sq_d;
            end
        end

        assign sq[g] = sq_q;
`else
        assign sq[g] = 1'b0;
`endif

        assign tick[g]        = tick_q;
        assign cfg_pending[g] = pend_q;
    end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Bench for clk_tick_gen with default parameters (CH=3, W=21, DIV_RST=4).
// Integer model of each channel (elapsed count, divisor, pending, tick parity) checked every cycle,
// plus hand-computed expectations at fixed cycle offsets from the start of counting.
module tb_clk_tick_gen;
    localparam int CH      = 3;
    localparam int W       = 21;
    localparam int DIV_RST = 4;
    localparam int CHW     = 2;
`ifdef CLK_TICK_GEN_SQ_EN
    localparam bit SQ_ON = 1'b1;
`else
    localparam bit SQ_ON = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic           en;
    logic           sync;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [W-1:0]   cfg_div;
    logic [CH-1:0]  tick;
    logic [CH-1:0]  sq;
    logic [CH-1:0]  cfg_pending;

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    clk_tick_gen #(.CH(CH), .W(W), .DIV_RST(DIV_RST)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .tick(tick), .sq(sq), .cfg_pending(cfg_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: elapsed cycles in the current period, active/pending divisor, tick count parity.
    int m_elapsed [CH] = '{default: 0};
    int m_div     [CH] = '{default: DIV_RST};
    int m_pdiv    [CH] = '{default: 0};
    bit m_pend    [CH] = '{default: 1'b0};
    bit m_tick    [CH] = '{default: 1'b0};
    int m_nticks  [CH] = '{default: 0};

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int c = 0; c < CH; c++) begin
                bit counting;
                bit wrapped;
                bit loads;
                if (!rst_n) begin
                    m_elapsed[c] = 0;
                    m_div[c]     = DIV_RST;
                    m_pdiv[c]    = 0;
                    m_pend[c]    = 1'b0;
                    m_tick[c]    = 1'b0;
                    m_nticks[c]  = 0;
                end else begin
                    counting = en && !sync && (m_div[c] > 0);
                    wrapped  = counting && (m_elapsed[c] + 1 == m_div[c]);
                    loads    = m_pend[c] && (sync || !en || m_div[c] == 0 || wrapped);
                    m_tick[c] = wrapped;
                    if (sync) begin
                        m_elapsed[c] = 0;
                        m_nticks[c]  = 0;
                    end else if (wrapped) begin
                        m_elapsed[c] = 0;
                        m_nticks[c]  = m_nticks[c] + 1;
                    end else if (counting) begin
                        m_elapsed[c] = m_elapsed[c] + 1;
                    end
                    if (loads) begin
                        m_div[c]  = m_pdiv[c];
                        m_pend[c] = 1'b0;
                    end
                    if (cfg_we && int'(cfg_ch) == c) begin
                        m_pdiv[c] = int'(cfg_div);
                        m_pend[c] = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    initial begin
        @(posedge clk);
        forever begin
            logic [CH-1:0] e_tick, e_sq, e_pend;
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                e_tick[c] = m_tick[c];
                e_sq[c]   = SQ_ON & m_nticks[c][0];
                e_pend[c] = m_pend[c];
            end
            checks = checks + 3;
            if (tick !== e_tick) begin
                failures++;
                $display("FAIL model_tick t=%0t got=%b exp=%b", $time, tick, e_tick);
            end
            if (sq !== e_sq) begin
                failures++;
                $display("FAIL model_sq t=%0t got=%b exp=%b", $time, sq, e_sq);
            end
            if (cfg_pending !== e_pend) begin
                failures++;
                $display("FAIL model_pending t=%0t got=%b exp=%b", $time, cfg_pending, e_pend);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", nm, k, act, exp);
        end
    endtask

    // Advance to the negedge that follows counting edge number kk.
    task automatic at(input int kk);
        while (k < kk) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wr(input logic [CHW-1:0] ch, input logic [W-1:0] dv);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_div = dv;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sync = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        repeat (3) @(negedge clk);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_sq", 32'(sq), 32'h0);
        chk("rst_pending", 32'(cfg_pending), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1; k = 0;

        // Default divisor 4, all channels in phase.
        at(3);  chk("first_tick_early", 32'(tick), 32'h0);
        at(4);  chk("first_tick", 32'(tick), 32'h7);
                chk("first_sq", 32'(sq), SQ_ON ? 32'h7 : 32'h0);
        at(8);  chk("second_tick", 32'(tick), 32'h7);
                chk("second_sq", 32'(sq), 32'h0);

        // ch1 divisor 10 written at cnt=1; applied at the wrap of the current period of 4.
        at(9);  wr(2'd1, 21'd10);
        at(10); cfg_we = 1'b0; chk("pend_ch1", 32'(cfg_pending), 32'h2);
        at(11); chk("pend_ch1_hold", 32'(cfg_pending), 32'h2);
        at(12); chk("wrap_old_div", 32'(tick), 32'h7);
                chk("pend_ch1_clr", 32'(cfg_pending), 32'h0);
        at(16); chk("ch1_skips", 32'(tick), 32'h5);
        at(22); chk("ch1_div10", 32'(tick), 32'h2);
        at(32); chk("all_align32", 32'(tick), 32'h7);

        // ch2 disabled with div 0, then div 1 gives a continuous tick.
        at(33); wr(2'd2, 21'd0);
        at(34); cfg_we = 1'b0;
        at(36); chk("ch2_last_wrap", 32'(tick), 32'h5);
        at(37); chk("ch2_off", 32'(tick), 32'h0);
        at(38); wr(2'd2, 21'd1);
        at(39); cfg_we = 1'b0;
                chk("pend_ch2", 32'(cfg_pending), 32'h4);
                chk("ch2_off2", 32'(tick), 32'h0);
        at(40); chk("ch2_apply_edge", 32'(tick), 32'h1);
                chk("pend_ch2_clr", 32'(cfg_pending), 32'h0);
        at(41); chk("ch2_div1", 32'(tick), 32'h4);
        at(42); chk("ch12_tick", 32'(tick), 32'h6);
        at(44); chk("ch02_tick", 32'(tick), 32'h5);

        // Freeze for 7 cycles mid-period; remaining cycles to next tick preserved.
        at(45); en = 1'b0;
        for (int j = 46; j <= 52; j++) begin
            at(j);
            chk("frozen_tick", 32'(tick), 32'h0);
        end
        en = 1'b1;
        at(53); chk("resume53", 32'(tick), 32'h4);
        at(54); chk("resume54", 32'(tick), 32'h4);
        at(55); chk("resume_ch0", 32'(tick), 32'h5);
        at(58); chk("resume58", 32'(tick), 32'h4);
        at(59); chk("resume_ch1", 32'(tick), 32'h7);

        // Sync together with a ch0 write; out-of-range write ignored.
        at(60); sync = 1'b1; wr(2'd0, 21'd3);
        at(61); sync = 1'b0; wr(2'd3, 21'd7);
                chk("sync_tick", 32'(tick), 32'h0);
                chk("sync_sq", 32'(sq), 32'h0);
                chk("sync_pend", 32'(cfg_pending), 32'h1);
        at(62); cfg_we = 1'b0;
                chk("ch3_ignored", 32'(cfg_pending), 32'h1);
        at(65); chk("sync_wrap4", 32'(tick), 32'h5);
                chk("sync_pend_clr", 32'(cfg_pending), 32'h0);
        at(68); chk("ch0_div3", 32'(tick), 32'h5);
        at(71); chk("all71", 32'(tick), 32'h7);

        // Asynchronous reset mid-cycle with a write pending.
        at(72); wr(2'd1, 21'd5);
        at(73); cfg_we = 1'b0;
                chk("pre_rst_pend", 32'(cfg_pending), 32'h2);
                chk("pre_rst_tick", 32'(tick), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tick", 32'(tick), 32'h0);
        chk("async_rst_sq", 32'(sq), 32'h0);
        chk("async_rst_pend", 32'(cfg_pending), 32'h0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1; k = 0;
        at(3); chk("post_rst_early", 32'(tick), 32'h0);
        at(4); chk("post_rst_tick", 32'(tick), 32'h7);
        at(7); chk("post_rst_gap", 32'(tick), 32'h0);
        at(8); chk("post_rst_div4", 32'(tick), 32'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
